// File: rtl/alu_serial_ctrl_if.sv
// rtl/alu_serial_ctrl_if.sv - start/done handshake and result bus of the bit-serial ALU sequencer
//
// Signals (directions as seen by the sequencer, modport slave):
//   start_i        in   request, sampled only while the sequencer is idle
//   src1_i/src2_i  in   WIDTH-bit operands A and B, captured on an accepted start
//   ALU_control_i  in   {A_invert, B_invert, operation[1:0]}, captured on an accepted start
//   busy_o         out  high while bits are being processed
//   done_o         out  one-cycle pulse when result and flags become valid
//   result_o       out  WIDTH-bit result, held until the next completion
//   zero_o         out  result_o == 0
//   cout_o         out  carry out of the MSB (arithmetic class only)
//   overflow_o     out  signed overflow (arithmetic class only)
// The requester uses modport master.

interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ALU_control_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  modport master (
    output start_i, src1_i, src2_i, ALU_control_i,
    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, ALU_control_i,
    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );

endinterface

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial 32-bit ALU built around a single 1-bit slice, LSB first
//
// Ports:
//   clk_i  in  clock, all state changes on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    alu_serial_ctrl_if.slave  operands/control in, result/flags/handshake out
//
// One operation takes WIDTH RUN cycles followed by one DONE cycle. The operand
// shift registers present bit i at position 0 in RUN cycle i; the slice result
// enters the result shift register at the MSB so that it is aligned after the
// last shift. Result and flags are registered only on the RUN->DONE transition,
// so they stay stable for the whole of the following operation.

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  alu_serial_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Carry into the bit currently at position 0 of the operand shift registers.
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // 1-bit ALU slice
  logic             bit_a, bit_b, bit_sum, bit_cout, bit_r;
  logic             last_bit;
  logic             arith, is_slt;
  logic             msb_ovf, slt_set;
  logic [WIDTH-1:0] shifted_res, final_res;

  always_comb begin
    bit_a    = a_sr_q[0] ^ ctl_q[3];
    bit_b    = b_sr_q[0] ^ ctl_q[2];
    bit_sum  = bit_a ^ bit_b ^ carry_q;
    bit_cout = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
    unique case (ctl_q[1:0])
      2'b00:   bit_r = bit_a & bit_b;
      2'b01:   bit_r = bit_a | bit_b;
      2'b10:   bit_r = bit_sum;
      default: bit_r = 1'b0;  // SLT: only bit 0 is set, at completion
    endcase
  end

  assign last_bit    = (cnt_q == CW'(WIDTH - 1));
  assign arith       = ctl_q[1];
  assign is_slt      = (ctl_q[1:0] == 2'b11);
  // At the MSB, carry_q is the carry into the MSB and bit_cout the carry out.
  assign msb_ovf     = carry_q ^ bit_cout;
  // Sign of the true difference: MSB of the wrapped sum corrected by overflow.
  assign slt_set     = bit_sum ^ msb_ovf;
  assign shifted_res = {bit_r, res_sr_q[WIDTH-1:1]};
  assign final_res   = is_slt ? WIDTH'(slt_set) : shifted_res;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      result_q <= '0;
      ctl_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      result_q <= result_d;
      ctl_q    <= ctl_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    result_d = result_q;
    ctl_d    = ctl_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          a_sr_d  = bus.src1_i;
          b_sr_d  = bus.src2_i;
          ctl_d   = bus.ALU_control_i;
          cnt_d   = '0;
          // B_invert doubles as the +1 of two's-complement negation.
          carry_d = bus.ALU_control_i[2];
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = shifted_res;
        carry_d  = bit_cout;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          result_d = final_res;
          zero_d   = (final_res == '0);
          cout_d   = arith & bit_cout;
          ovf_d    = arith & msb_ovf;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy_o     = (state_q == S_RUN);
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.cout_o     = cout_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - self-checking bench for the bit-serial ALU sequencer

module tb_alu_serial_ctrl;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Values expected on result_o from the last completed operation.
  logic [W-1:0] held_res = '0;

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the (optionally inverted) operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl,
                       output logic [W-1:0] res, output logic z, output logic co, output logic ov);
    logic [W-1:0] aa, bb;
    logic [W:0]   sum;
    aa  = ctl[3] ? ~a : a;
    bb  = ctl[2] ? ~b : b;
    sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ctl[2]};
    co  = 1'b0;
    ov  = 1'b0;
    case (ctl[1:0])
      2'b00: res = aa & bb;
      2'b01: res = aa | bb;
      default: begin
        co = sum[W];
        ov = (aa[W-1] == bb[W-1]) && (sum[W-1] != aa[W-1]);
        if (ctl[1:0] == 2'b10) res = sum[W-1:0];
        else                   res = {{(W-1){1'b0}}, sum[W-1] ^ ov};
      end
    endcase
    z = (res == '0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    check({tag, "_done"}, 64'(bus.done_o), 64'd0);
    check({tag, "_res"},  64'(bus.result_o), 64'd0);
    check({tag, "_zero"}, 64'(bus.zero_o), 64'd1);
    check({tag, "_cout"}, 64'(bus.cout_o), 64'd0);
    check({tag, "_ovf"},  64'(bus.overflow_o), 64'd0);
  endtask

  // Runs one operation. Start is raised at a negedge and accepted at the next
  // posedge (E0). Sample n is the n-th negedge after E0. Extra start pulses
  // with junk operands are driven after samples p1/p2 (0 = none). If rst_at
  // is nonzero, reset is asserted after that sample and the op is abandoned.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] ctl, input int p1, input int p2, input int rst_at);
    logic [W-1:0] er;
    logic ez, ec, eo;
    int busy_cnt, done_at;
    model(a, b, ctl, er, ez, ec, eo);
    @(negedge clk);
    bus.src1_i = a;
    bus.src2_i = b;
    bus.ALU_control_i = ctl;
    bus.start_i = 1'b1;
    busy_cnt = 0;
    done_at = 0;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) done_at = n;
      if (n == 16) check({tag, "_held"}, 64'(bus.result_o), 64'(held_res));
      bus.src1_i = $urandom;
      bus.src2_i = $urandom;
      bus.ALU_control_i = 4'($urandom);
      bus.start_i = (n == p1 || n == p2);
      if (rst_at != 0 && n == rst_at) begin
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check_reset_values({tag, "_rst"});
        held_res = '0;
        return;
      end
    end
    bus.start_i = 1'b0;
    check({tag, "_lat"}, 64'(done_at), 64'd33);
    if (done_at == 0) return;
    check({tag, "_busy"}, 64'(busy_cnt), 64'd32);
    check({tag, "_res"},  64'(bus.result_o), 64'(er));
    check({tag, "_zero"}, 64'(bus.zero_o), 64'(ez));
    check({tag, "_cout"}, 64'(bus.cout_o), 64'(ec));
    check({tag, "_ovf"},  64'(bus.overflow_o), 64'(eo));
    held_res = er;
    @(negedge clk);
    check({tag, "_pulse"}, 64'({bus.done_o, bus.busy_o}), 64'd0);
  endtask

  // Counts done pulses over a window; none may appear while idle.
  task automatic quiet(input string tag, input int cycles);
    int dones;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) dones++;
    end
    check({tag, "_quiet"}, 64'(dones), 64'd0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.src1_i = '0;
    bus.src2_i = '0;
    bus.ALU_control_i = '0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 4'b0010, 0, 0, 0);
    run_op("sub_ovf",  32'h80000000, 32'h00000001, 4'b0110, 0, 0, 0);
    run_op("sub_zero", 32'd5, 32'd5, 4'b0110, 0, 0, 0);
    run_op("slt_neg",  32'hFFFFFFFB, 32'h00000003, 4'b0111, 0, 0, 0);
    run_op("slt_ovf",  32'h7FFFFFFF, 32'h80000000, 4'b0111, 0, 0, 0);
    run_op("and",      32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 0, 0, 0);
    run_op("or",       32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 0, 0, 0);
    run_op("nor",      32'h00000000, 32'h00000000, 4'b1100, 0, 0, 0);

    run_op("ignore", 32'h12345678, 32'h0F0F0F0F, 4'b0010, 5, 20, 0);
    quiet("ignore", 40);

    run_op("abort", 32'hDEADBEEF, 32'h01234567, 4'b0010, 0, 0, 10);
    quiet("abort", 40);
    check_reset_values("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 32'd2, 32'd3, 4'b0010, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (k % 5 == 0) ? ra : $urandom;
      run_op($sformatf("rnd%0d", k), ra, rb, 4'($urandom), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
